// File: rtl/brom_emission_fetch.sv
// Address generator and read sequencer for the emission BROM: streams (state, score) pairs
// for every HMM state of an accepted observation symbol through a credit-controlled output FIFO.
module brom_emission_fetch #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 14,
  parameter int ST_W       = 6,
  parameter int SYM_W      = 7,
  parameter int ROM_LAT    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              obs_valid,
  output logic              obs_ready,
  input  logic [SYM_W-1:0]  obs_sym,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_dout,
  output logic              em_valid,
  input  logic              em_ready,
  output logic [ST_W-1:0]   em_state,
  output logic [DATA_W-1:0] em_data,
  output logic              em_last,
  output logic              busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam int ENT_W = ST_W + 1 + DATA_W;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [1:0]        state_q, state_d;
  logic [SYM_W-1:0]  sym_q, sym_d;
  logic [ST_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;

  logic [ROM_LAT-1:0] pipe_vld_q, pipe_vld_d;
  logic [ROM_LAT-1:0] pipe_last_q, pipe_last_d;
  logic [ST_W-1:0]    pipe_st_q [ROM_LAT];
  logic [ST_W-1:0]    pipe_st_d [ROM_LAT];

  logic [ENT_W-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0] fifo_mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;

  logic             issue, push, pop;
  logic [ENT_W-1:0] head;
  int               inflight, credit;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign obs_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rom_addr  = rom_addr_q;
  assign head      = fifo_mem_q[rd_ptr_q];
  assign em_valid  = (fifo_cnt_q != '0);
  assign em_state  = em_valid ? head[ENT_W-1 -: ST_W] : '0;
  assign em_last   = em_valid & head[DATA_W];
  assign em_data   = em_valid ? head[DATA_W-1:0] : '0;

  always_comb begin
    state_d     = state_q;
    sym_d       = sym_q;
    cnt_d       = cnt_q;
    rom_addr_d  = rom_addr_q;
    pipe_vld_d  = pipe_vld_q;
    pipe_last_d = pipe_last_q;
    pipe_st_d   = pipe_st_q;
    fifo_mem_d  = fifo_mem_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;

    // Reads already in flight hold a FIFO slot, so the FIFO can never overflow.
    inflight = 0;
    for (int i = 0; i < ROM_LAT; i++) inflight += int'(pipe_vld_q[i]);
    credit = FIFO_DEPTH - int'(fifo_cnt_q) - inflight;

    issue = (state_q == S_FETCH) && (credit > 0);
    push  = pipe_vld_q[ROM_LAT-1];
    pop   = em_valid && em_ready;

    pipe_vld_d[0]  = issue;
    pipe_st_d[0]   = cnt_q;
    pipe_last_d[0] = (cnt_q == '1);
    for (int i = 1; i < ROM_LAT; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_st_d[i]   = pipe_st_q[i-1];
      pipe_last_d[i] = pipe_last_q[i-1];
    end

    if (push) begin
      fifo_mem_d[wr_ptr_q] = {pipe_st_q[ROM_LAT-1], pipe_last_q[ROM_LAT-1], rom_dout};
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);

    case (state_q)
      S_IDLE: begin
        if (obs_valid) begin
          sym_d   = obs_sym;
          cnt_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (issue) begin
          rom_addr_d = {cnt_q, sym_q};
          cnt_d      = cnt_q + ST_W'(1);
          if (cnt_q == '1) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (fifo_cnt_d == '0 && pipe_vld_d == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sym_q       <= '0;
      cnt_q       <= '0;
      rom_addr_q  <= '0;
      pipe_vld_q  <= '0;
      pipe_last_q <= '0;
      for (int i = 0; i < ROM_LAT; i++) pipe_st_q[i] <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      sym_q       <= sym_d;
      cnt_q       <= cnt_d;
      rom_addr_q  <= rom_addr_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_last_q <= pipe_last_d;
      pipe_st_q   <= pipe_st_d;
      fifo_mem_q  <= fifo_mem_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
    end
  end

endmodule

// File: tb/tb_brom_emission_fetch.sv
// Randomised bench for brom_emission_fetch: a queue of expected (state, last, score) entries
// built from the address rule is compared against the emission stream every cycle.
module tb_brom_emission_fetch;

  localparam int ST_W   = 6;
  localparam int SYM_W  = 7;
  localparam int DATA_W = 14;
  localparam int ADDR_W = 13;

  logic              clk, rst_n;
  logic              obs_valid, obs_ready;
  logic [SYM_W-1:0]  obs_sym;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_dout;
  logic              em_valid, em_ready, em_last, busy;
  logic [ST_W-1:0]   em_state;
  logic [DATA_W-1:0] em_data;

  int   checkCount  = 0;
  int   errorCount  = 0;
  int   popCount    = 0;
  int   acceptCount = 0;
  bit   busyModel   = 0;
  bit   randomReady = 0;
  logic [20:0] expQ[$];

  brom_emission_fetch dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .obs_valid(obs_valid),
    .obs_ready(obs_ready),
    .obs_sym  (obs_sym),
    .rom_addr (rom_addr),
    .rom_dout (rom_dout),
    .em_valid (em_valid),
    .em_ready (em_ready),
    .em_state (em_state),
    .em_data  (em_data),
    .em_last  (em_last),
    .busy     (busy)
  );

  // Clock generation
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // BROM stand-in: one-cycle registered read with a recognisable data pattern
  always @(posedge clk) rom_dout <= rom_addr ^ 14'h2A5A;

  // Random downstream backpressure when enabled
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (randomReady) em_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Expected emission for a state: address is state*128 + symbol, score is the ROM pattern
  function automatic logic [20:0] makeEntry(input int st, input int sym);
    int addr;
    logic [13:0] score;
    addr  = st * 128 + sym;
    score = 14'(addr) ^ 14'h2A5A;
    return {6'(st), 1'(st == 63), score};
  endfunction

  // Reference model and per-cycle comparison
  initial begin
    logic [20:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        expQ.delete();
        busyModel = 0;
      end else begin
        checkOutput("busy", 32'(busy), 32'(busyModel));
        checkOutput("obs_ready", 32'(obs_ready), 32'(!busyModel));
        if (em_valid) begin
          if (expQ.size() == 0) begin
            checkOutput("em_valid with nothing expected", 32'(em_valid), 32'(0));
          end else begin
            e = expQ[0];
            checkOutput("em_state", 32'(em_state), 32'(e[20:15]));
            checkOutput("em_last", 32'(em_last), 32'(e[14]));
            checkOutput("em_data", 32'(em_data), 32'(e[13:0]));
            if (em_ready) begin
              void'(expQ.pop_front());
              popCount++;
              if (e[14]) busyModel = 0;
            end
          end
        end
        if (obs_valid && obs_ready) begin
          for (int st = 0; st < 64; st++) expQ.push_back(makeEntry(st, int'(obs_sym)));
          busyModel = 1;
          acceptCount++;
        end
      end
    end
  end

  // Present one symbol and hold it until accepted
  task automatic applyStimulus(input logic [SYM_W-1:0] sym);
    bit ok;
    ok = 0;
    @(posedge clk);
    #1;
    obs_valid = 1'b1;
    obs_sym   = sym;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (obs_ready) begin
        ok = 1;
        break;
      end
    end
    checkOutput("symbol accepted in time", 32'(ok), 32'(1));
    @(posedge clk);
    #1;
    obs_valid = 1'b0;
  endtask

  task automatic waitIdle();
    bit done;
    done = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (!busy && !em_valid && expQ.size() == 0) begin
        done = 1;
        break;
      end
    end
    checkOutput("stream drained in time", 32'(done), 32'(1));
  endtask

  // Watchdog
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    errorCount++;
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $fatal(1, "[TB] watchdog expired");
  end

  // Test sequence
  initial begin
    int base;
    bit found;
    logic [SYM_W-1:0] sym;
    logic [ADDR_W-1:0] frozenAddr;

    rst_n     = 1'b0;
    obs_valid = 1'b0;
    obs_sym   = '0;
    em_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset em_valid", 32'(em_valid), 32'(0));
    checkOutput("reset rom_addr", 32'(rom_addr), 32'(0));
    checkOutput("reset busy", 32'(busy), 32'(0));
    checkOutput("reset obs_ready", 32'(obs_ready), 32'(1));
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] test 1: symbol 5, em_ready high");
    applyStimulus(7'd5);
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("em_valid two edges after accept", 32'(em_valid), 32'(0));
    @(posedge clk);
    #1;
    checkOutput("em_valid three edges after accept", 32'(em_valid), 32'(1));
    checkOutput("first em_state", 32'(em_state), 32'(0));
    checkOutput("first em_data", 32'(em_data), 32'(14'h2A5F));
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (em_valid && em_last) begin
        found = 1;
        break;
      end
    end
    checkOutput("last seen", 32'(found), 32'(1));
    checkOutput("last em_state", 32'(em_state), 32'(63));
    checkOutput("last em_data", 32'(em_data), 32'(14'h35DF));
    waitIdle();
    checkOutput("busy after stream", 32'(busy), 32'(0));
    checkOutput("obs_ready after stream", 32'(obs_ready), 32'(1));

    $display("[TB] test 2: backpressure after state 1");
    sym  = 7'($urandom_range(0, 127));
    base = popCount;
    applyStimulus(sym);
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (em_valid && em_ready && em_state == 6'd1) begin
        found = 1;
        break;
      end
    end
    checkOutput("state 1 reached", 32'(found), 32'(1));
    @(posedge clk);
    #1;
    em_ready = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    frozenAddr = rom_addr;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("rom_addr frozen", 32'(rom_addr), 32'(frozenAddr));
    checkOutput("rom_addr last issued", 32'(rom_addr), 32'(5 * 128 + int'(sym)));
    checkOutput("head during stall", 32'(em_state), 32'(2));
    checkOutput("valid during stall", 32'(em_valid), 32'(1));
    em_ready = 1'b1;
    waitIdle();
    checkOutput("emissions with stall", 32'(popCount - base), 32'(64));

    $display("[TB] test 3: random backpressure, symbols 0 and 127");
    base        = popCount;
    randomReady = 1;
    applyStimulus(7'd0);
    applyStimulus(7'd127);
    waitIdle();
    randomReady = 0;
    @(posedge clk);
    #1;
    em_ready = 1'b1;
    checkOutput("emissions for two symbols", 32'(popCount - base), 32'(128));

    $display("[TB] test 4: obs_valid held during fetch");
    base = acceptCount;
    applyStimulus(7'd33);
    @(posedge clk);
    #1;
    obs_valid = 1'b1;
    obs_sym   = 7'd90;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("obs_ready during fetch", 32'(obs_ready), 32'(0));
    checkOutput("accepts during fetch", 32'(acceptCount - base), 32'(1));
    found = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (obs_ready) begin
        found = 1;
        break;
      end
    end
    checkOutput("second symbol accepted", 32'(found), 32'(1));
    @(posedge clk);
    #1;
    obs_valid = 1'b0;
    waitIdle();
    checkOutput("accepts total", 32'(acceptCount - base), 32'(2));

    $display("[TB] test 5: reset mid-stream");
    applyStimulus(7'($urandom_range(0, 127)));
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (em_valid && em_state == 6'd30) begin
        found = 1;
        break;
      end
    end
    checkOutput("state 30 reached", 32'(found), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid reset em_valid", 32'(em_valid), 32'(0));
    checkOutput("mid reset em_state", 32'(em_state), 32'(0));
    checkOutput("mid reset em_data", 32'(em_data), 32'(0));
    checkOutput("mid reset em_last", 32'(em_last), 32'(0));
    checkOutput("mid reset busy", 32'(busy), 32'(0));
    checkOutput("mid reset rom_addr", 32'(rom_addr), 32'(0));
    checkOutput("mid reset obs_ready", 32'(obs_ready), 32'(1));
    @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    base  = popCount;
    applyStimulus(7'd9);
    waitIdle();
    checkOutput("emissions after reset", 32'(popCount - base), 32'(64));

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
